ex_muldiv_ctrl: RTL
===================

# ex_muldiv_ctrl

Multi-cycle sequencer for the RV32M multiply/divide instructions in the execute stage. While an M-extension instruction occupies EX, it captures the forwarded operands and drives a stall request that holds IF/ID/EX. It iterates a radix-2 shift-add/restoring-divide datapath for 32 cycles and presents a one-cycle result that the EX result mux selects instead of the ALU output. It sits beside the ALU and before the EX/MEM register, and obeys the same EX flush as that register.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iterations per operation; must equal XLEN.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX holds a live instruction.
- is_md  in  1  decoded M-extension instruction in EX.
- funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  32  rs1 after forwarding.
- op_b  in  32  rs2 after forwarding.
- ex_flush  in  1  kill the instruction in EX (branch/jump redirect).
- stall_req  out  1  hold IF/ID/EX; EX/MEM is not loaded.
- md_done  out  1  md_result valid this cycle; EX/MEM loads it.
- md_result  out  32  selected result.
- busy  out  1  FSM not IDLE.

## Operation
- States: IDLE, RUN, DONE (2-bit, encoded in package).
- IDLE: on ex_valid && is_md && !ex_flush, latch |op_a|, |op_b| (per signedness of funct3), the result sign, funct3 and special-case flags; clear counter, accumulators; go RUN.
- RUN: one iteration per cycle; counter 0..31; at counter==31 go DONE.
  - Multiply: 64-bit product accumulate, shift-add on multiplier LSB.
  - Divide: restoring, 33-bit partial remainder, one quotient bit per cycle.
- DONE: md_done=1, md_result driven from registered final value; unconditional return to IDLE next cycle.
- Sign fix in DONE: negate product/quotient if the sign flag is set; remainder takes the sign of the dividend.
- MUL returns low word; MULH/MULHSU/MULHU return high word. MULHSU: op_a signed, op_b unsigned.
- Divide by zero: quotient 0xFFFFFFFF (both DIV and DIVU), remainder = op_a unmodified.
- Overflow DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Special cases are still sequenced through all 32 iterations (fixed latency); only the final select differs.
- ex_flush in any state: next state IDLE, md_done suppressed; flush takes priority over start and over DONE.

## Timing
- stall_req = ex_valid && is_md && (state==IDLE || state==RUN) && !ex_flush; combinational, low in DONE.
- Latency: accept cycle (IDLE) + 32 RUN + 1 DONE = instruction held in EX for 34 cycles, with 33 stall cycles.
- md_done is high for exactly one cycle, and only in DONE.
- Back-to-back M-ops: the second is accepted in the IDLE cycle immediately after DONE.
- Reset (async, reset_n low): state IDLE, counter 0, accumulators 0; stall_req=0 (with reset_n low the state is IDLE, but stall_req follows the IDLE formula, so the top level gates EX valid during reset), md_done=0, md_result=0, busy=0.
- Reset mid-RUN aborts with no md_done.

## Configuration
- EX_MULDIV_FAST_MUL_EN defined: MUL* ops compute with a single-cycle 33x33 signed multiply in the accept cycle and go IDLE->DONE directly (1 stall cycle, 2 cycles in EX). Divides are unchanged.
- Undefined: all ops are iterative, 34 cycles in EX.

## Structure
- Package riscv_md_pkg: funct3 encodings (MD_MUL..MD_REMU), state encoding, ITER constant, DIV0_QUOT constant (32'hFFFFFFFF).
- One sub-module, md_iter_dp: operand registers, counter, 64-bit accumulator, shift/subtract step and sign fix. Controlled by start/step/abort from the FSM in ex_muldiv_ctrl.

## Test plan
- MUL 7 * 0xFFFFFFFD -> md_result 0xFFFFFFEB, md_done at cycle 33 after accept, stall_req high for 33 cycles.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF.
- DIVU 100 / 0 -> 0xFFFFFFFF; REMU 100 / 0 -> 100; latency still 34 cycles.
- ex_flush asserted on RUN counter 10 -> IDLE next cycle, stall_req low, no md_done; a new DIVU 9/2 immediately after returns 4.
- reset_n pulsed low mid-RUN -> all outputs 0 asynchronously; back-to-back MUL then DIV each produce exactly one md_done. With EX_MULDIV_FAST_MUL_EN defined, MUL completes after 1 stall cycle.

Source files
------------

// File: rtl/riscv_md_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide sequencer.
// The EX_MULDIV_FAST_MUL_EN macro (single-cycle multiply) is consumed by the modules that import this package.
package riscv_md_pkg;

   localparam int          MD_XLEN   = 32;
   localparam int          MD_ITER   = 32;
   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } md_state_e;

   // rs1 is treated as two's complement for these ops
   function automatic logic md_a_signed(input logic [2:0] f3);
      logic s;
      case (f3)
         MD_MULH, MD_MULHSU, MD_DIV, MD_REM: s = 1'b1;
         default:                            s = 1'b0;
      endcase
      return s;
   endfunction

   function automatic logic md_b_signed(input logic [2:0] f3);
      logic s;
      case (f3)
         MD_MULH, MD_DIV, MD_REM: s = 1'b1;
         default:                 s = 1'b0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// Pipeline-side handshake between the EX stage and the multiply/divide sequencer.
// Shared by builds with and without EX_MULDIV_FAST_MUL_EN.
interface ex_muldiv_ctrl_if;
   import riscv_md_pkg::*;

   logic               ex_valid;
   logic               is_md;
   logic [2:0]         funct3;
   logic [MD_XLEN-1:0] op_a;
   logic [MD_XLEN-1:0] op_b;
   logic               ex_flush;
   logic               stall_req;
   logic               md_done;
   logic [MD_XLEN-1:0] md_result;
   logic               busy;

   modport master (
      output ex_valid, is_md, funct3, op_a, op_b, ex_flush,
      input  stall_req, md_done, md_result, busy
   );

   modport slave (
      input  ex_valid, is_md, funct3, op_a, op_b, ex_flush,
      output stall_req, md_done, md_result, busy
   );

endinterface

// File: rtl/md_iter_dp.sv
// Radix-2 shift-add multiply / restoring divide datapath with final sign fix.
// With EX_MULDIV_FAST_MUL_EN defined, multiplies load the full product at start.
module md_iter_dp
   import riscv_md_pkg::*;
#(
   parameter int XLEN = MD_XLEN,
   parameter int ITER = MD_ITER
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            start,
   input  logic            step,
   input  logic            abort,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            cnt_last,
   output logic [XLEN-1:0] result
);

   localparam int              CW     = $clog2(ITER);
   localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] ONES_X = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};

   logic [XLEN-1:0]   a_raw_q;
   logic [XLEN-1:0]   opb_q;
   logic [2*XLEN-1:0] acc_q;
   logic [CW-1:0]     cnt_q;
   logic [2:0]        f3_q;
   logic              neg_q;
   logic              rneg_q;
   logic              div0_q;
   logic              ovf_q;

   logic              a_neg_s;
   logic              b_neg_s;
   logic              div0_s;
   logic              ovf_s;
   logic [XLEN-1:0]   abs_a_s;
   logic [XLEN-1:0]   abs_b_s;
   logic [XLEN:0]     sum_s;
   logic [XLEN:0]     shl_s;
   logic [XLEN:0]     diff_s;
   logic [2*XLEN-1:0] mul_nxt_s;
   logic [2*XLEN-1:0] div_nxt_s;
   logic [2*XLEN-1:0] acc_nxt_s;
   logic [2*XLEN-1:0] prod_fix_s;
   logic [XLEN-1:0]   quot_s;
   logic [XLEN-1:0]   rem_s;

   assign a_neg_s = md_a_signed(funct3) & op_a[XLEN-1];
   assign b_neg_s = md_b_signed(funct3) & op_b[XLEN-1];
   assign abs_a_s = a_neg_s ? (ZERO_X - op_a) : op_a;
   assign abs_b_s = b_neg_s ? (ZERO_X - op_b) : op_b;
   assign div0_s  = funct3[2] && (op_b == ZERO_X);
   assign ovf_s   = ((funct3 == MD_DIV) || (funct3 == MD_REM)) &&
                    (op_a == MIN_X) && (op_b == ONES_X);
   assign cnt_last = (cnt_q == CW'(ITER - 1));

`ifdef EX_MULDIV_FAST_MUL_EN
   logic signed [2*XLEN-1:0] fa_s;
   logic signed [2*XLEN-1:0] fb_s;
   logic signed [2*XLEN-1:0] fprod_s;

   // 33x33 signed product: the 33rd bit is the op's sign extension of each operand
   assign fa_s    = {{XLEN{md_a_signed(funct3) & op_a[XLEN-1]}}, op_a};
   assign fb_s    = {{XLEN{md_b_signed(funct3) & op_b[XLEN-1]}}, op_b};
   assign fprod_s = fa_s * fb_s;
`endif

   // One iteration: acc holds {partial product hi, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      sum_s     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {1'b0, ZERO_X});
      mul_nxt_s = {sum_s, acc_q[XLEN-1:1]};
      shl_s     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      diff_s    = shl_s - {1'b0, opb_q};
      if (!diff_s[XLEN]) begin
         div_nxt_s = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         div_nxt_s = {shl_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
      acc_nxt_s = f3_q[2] ? div_nxt_s : mul_nxt_s;
   end

   // Operand capture, iteration counter and accumulator
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_raw_q <= ZERO_X;
         opb_q   <= ZERO_X;
         acc_q   <= {(2*XLEN){1'b0}};
         cnt_q   <= {CW{1'b0}};
         f3_q    <= 3'b000;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         div0_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (abort) begin
         cnt_q <= {CW{1'b0}};
      end else if (start) begin
         a_raw_q <= op_a;
         opb_q   <= abs_b_s;
         f3_q    <= funct3;
         cnt_q   <= {CW{1'b0}};
         rneg_q  <= a_neg_s;
         div0_q  <= div0_s;
         ovf_q   <= ovf_s;
`ifdef EX_MULDIV_FAST_MUL_EN
         if (!funct3[2]) begin
            acc_q <= fprod_s;
            neg_q <= 1'b0;
         end else begin
            acc_q <= {ZERO_X, abs_a_s};
            neg_q <= a_neg_s ^ b_neg_s;
         end
`else
         acc_q <= {ZERO_X, abs_a_s};
         neg_q <= a_neg_s ^ b_neg_s;
`endif
      end else if (step) begin
         acc_q <= acc_nxt_s;
         cnt_q <= cnt_q + CW'(1);
      end
   end

   // Final select; special cases override the iterated quotient/remainder
   always_comb begin
      prod_fix_s = neg_q ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
      if (div0_q) begin
         quot_s = DIV0_QUOT;
         rem_s  = a_raw_q;
      end else if (ovf_q) begin
         quot_s = MIN_X;
         rem_s  = ZERO_X;
      end else begin
         quot_s = neg_q  ? (ZERO_X - acc_q[XLEN-1:0])      : acc_q[XLEN-1:0];
         rem_s  = rneg_q ? (ZERO_X - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
      end
      case (f3_q)
         MD_MUL:                      result = prod_fix_s[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix_s[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:             result = quot_s;
         MD_REM, MD_REMU:             result = rem_s;
         default:                     result = ZERO_X;
      endcase
   end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage sequencer for RV32M ops: stalls the front end, steps md_iter_dp, emits a one-cycle result.
// Define EX_MULDIV_FAST_MUL_EN to finish multiplies in the accept cycle (IDLE -> DONE).
module ex_muldiv_ctrl
   import riscv_md_pkg::*;
#(
   parameter int XLEN = MD_XLEN,
   parameter int ITER = MD_ITER
) (
   input logic              clock,
   input logic              reset_n,
   ex_muldiv_ctrl_if.slave  md_if
);

   md_state_e       state_q;
   md_state_e       state_d;
   logic            busy_q;
   logic            start_s;
   logic            step_s;
   logic            done_s;
   logic            cnt_last_s;
   logic [XLEN-1:0] dp_result_s;

   assign start_s = (state_q == ST_IDLE) && md_if.ex_valid && md_if.is_md && !md_if.ex_flush;
   assign step_s  = (state_q == ST_RUN) && !md_if.ex_flush;
   assign done_s  = (state_q == ST_DONE) && !md_if.ex_flush;

   assign md_if.stall_req = md_if.ex_valid && md_if.is_md && !md_if.ex_flush &&
                            ((state_q == ST_IDLE) || (state_q == ST_RUN));
   assign md_if.md_done   = done_s;
   assign md_if.md_result = done_s ? dp_result_s : {XLEN{1'b0}};
   assign md_if.busy      = busy_q;

   // Next state: flush wins over start and over completion
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (md_if.ex_flush) begin
               state_d = ST_IDLE;
            end else if (start_s) begin
`ifdef EX_MULDIV_FAST_MUL_EN
               state_d = md_if.funct3[2] ? ST_RUN : ST_DONE;
`else
               state_d = ST_RUN;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (md_if.ex_flush) begin
               state_d = ST_IDLE;
            end else if (cnt_last_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register with registered busy flag
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   md_iter_dp #(
      .XLEN (XLEN),
      .ITER (ITER)
   ) u_dp (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start_s),
      .step     (step_s),
      .abort    (md_if.ex_flush),
      .funct3   (md_if.funct3),
      .op_a     (md_if.op_a),
      .op_b     (md_if.op_b),
      .cnt_last (cnt_last_s),
      .result   (dp_result_s)
   );

endmodule
